// File: rtl/sa_ctrl.sv
// Job sequencer for a ROWS x COLS weight-stationary systolic array.
// It preloads the weights, streams the input vectors, drains the array, and drives the buffer read/write ports.
module sa_ctrl #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int ADDR_W = 8,
  parameter int M_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W-1:0] cfg_in_base,
  input  logic [ADDR_W-1:0] cfg_out_base,
  input  logic [M_W-1:0]    cfg_m,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  output logic              in_rd_en,
  output logic [ADDR_W-1:0] in_rd_addr,
  output logic              sa_preload,
  output logic              sa_en,
  output logic              sa_in_zero,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr
);

  localparam int LAT = ROWS + COLS - 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRELOAD = 2'd1;
  localparam logic [1:0] ST_STREAM  = 2'd2;
  localparam logic [1:0] ST_FLUSH   = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_w_base;
  logic [ADDR_W-1:0] r_in_base;
  logic [ADDR_W-1:0] r_out_base;
  logic [M_W-1:0]    r_m;
  logic [ADDR_W-1:0] r_k;
  logic [M_W-1:0]    r_j;
  logic [M_W-1:0]    r_n;
  logic              r_done;
  logic              r_rd_q;
  logic              r_preload;
  logic [LAT-1:0]    r_vpipe;

  logic w_abort;
  logic w_accept;
  logic w_hold;
  logic w_in_rd;
  logic w_sa_en;
  logic w_out_wr;
  logic w_last_rd;
  logic w_last_wr;

  // Handshake and stall decode shared by both register blocks
  always_comb begin
    w_abort   = abort && (r_state != ST_IDLE);
    w_accept  = (r_state == ST_IDLE) && start && (cfg_m != {M_W{1'b0}});
    w_hold    = ((r_state == ST_STREAM) || (r_state == ST_FLUSH)) && !out_ready;
    w_in_rd   = (r_state == ST_STREAM) && out_ready;
    w_sa_en   = (r_rd_q || (r_state == ST_FLUSH)) && out_ready;
    w_out_wr  = r_vpipe[LAT-1] && w_sa_en;
    w_last_rd = w_in_rd && (r_j == (r_m - M_W'(1)));
    w_last_wr = w_out_wr && (r_n == (r_m - M_W'(1)));
  end

  // Outputs decoded only from registers, except where out_ready gates the current cycle
  always_comb begin
    busy        = (r_state != ST_IDLE);
    done        = r_done;
    state       = r_state;
    w_rd_en     = (r_state == ST_PRELOAD);
    w_rd_addr   = (r_state == ST_PRELOAD) ? (r_w_base + r_k) : {ADDR_W{1'b0}};
    in_rd_en    = w_in_rd;
    in_rd_addr  = (r_state == ST_STREAM) ? (r_in_base + ADDR_W'(r_j)) : {ADDR_W{1'b0}};
    sa_preload  = r_preload;
    sa_en       = w_sa_en;
    sa_in_zero  = w_sa_en && !r_rd_q;
    out_wr_en   = w_out_wr;
    out_wr_addr = (r_state != ST_IDLE) ? (r_out_base + ADDR_W'(r_n)) : {ADDR_W{1'b0}};
  end

  // Job FSM, latched configuration, preload/read counters and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_w_base   <= {ADDR_W{1'b0}};
      r_in_base  <= {ADDR_W{1'b0}};
      r_out_base <= {ADDR_W{1'b0}};
      r_m        <= {M_W{1'b0}};
      r_k        <= {ADDR_W{1'b0}};
      r_j        <= {M_W{1'b0}};
      r_done     <= 1'b0;
    end else if (w_abort) begin
      r_state <= ST_IDLE;
      r_k     <= {ADDR_W{1'b0}};
      r_j     <= {M_W{1'b0}};
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_w_base   <= cfg_w_base;
            r_in_base  <= cfg_in_base;
            r_out_base <= cfg_out_base;
            r_m        <= cfg_m;
            r_k        <= {ADDR_W{1'b0}};
            r_j        <= {M_W{1'b0}};
            r_state    <= ST_PRELOAD;
          end else if (start) begin
            // An empty job completes immediately without touching any buffer
            r_done <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_PRELOAD: begin
          if (r_k == ADDR_W'(ROWS - 1)) begin
            r_k     <= {ADDR_W{1'b0}};
            r_state <= ST_STREAM;
          end else begin
            r_k <= r_k + ADDR_W'(1);
          end
        end
        ST_STREAM: begin
          if (w_in_rd) begin
            r_j <= r_j + M_W'(1);
            if (w_last_rd) begin
              r_state <= ST_FLUSH;
            end else begin
              r_state <= ST_STREAM;
            end
          end else begin
            r_j <= r_j;
          end
        end
        ST_FLUSH: begin
          if (w_last_wr) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_FLUSH;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-latency tracking, valid pipe and output write counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_q    <= 1'b0;
      r_preload <= 1'b0;
      r_vpipe   <= {LAT{1'b0}};
      r_n       <= {M_W{1'b0}};
    end else if (w_abort || w_accept) begin
      r_rd_q    <= 1'b0;
      r_preload <= 1'b0;
      r_vpipe   <= {LAT{1'b0}};
      r_n       <= {M_W{1'b0}};
    end else begin
      r_preload <= (r_state == ST_PRELOAD);
      // During a stall the pending read data is held, so its flag must be held too
      if (!w_hold) begin
        r_rd_q <= w_in_rd;
      end else begin
        r_rd_q <= r_rd_q;
      end
      if (w_sa_en) begin
        r_vpipe <= {r_vpipe[LAT-2:0], r_rd_q};
      end else begin
        r_vpipe <= r_vpipe;
      end
      if (w_out_wr) begin
        r_n <= r_n + M_W'(1);
      end else begin
        r_n <= r_n;
      end
    end
  end

endmodule
